// File: rtl/histogram_peak_locator.sv
// Walks all 256 x/y histogram bin pairs and reports, per axis, the peak bin, its count and
// the first/last bin whose count reaches a latched occupancy threshold.
module histogram_peak_locator (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [8:0] threshold,
  output logic       readHistogram,
  input  logic [8:0] xHistogramOut,
  input  logic [8:0] yHistogramOut,
  input  logic       xValid,
  input  logic       yValid,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] xPeak,
  output logic [7:0] yPeak,
  output logic [8:0] xPeakCount,
  output logic [8:0] yPeakCount,
  output logic [7:0] xMin,
  output logic [7:0] xMax,
  output logic [7:0] yMin,
  output logic [7:0] yMax,
  output logic       boxValid
);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StUpdate, StDone} state_e;

  typedef struct packed {
    logic [7:0] peak;
    logic [8:0] cnt;
    logic [7:0] lo;
    logic [7:0] hi;
    logic       occ;
  } axis_t;

  // Strict '>' keeps the lowest index on ties; the first occupied bin seeds both bounds.
  function automatic axis_t axis_step(input axis_t a, input logic [8:0] smp,
                                      input logic [7:0] idx, input logic [8:0] thr);
    axis_t r;
    r = a;
    if (smp > a.cnt) begin
      r.peak = idx;
      r.cnt  = smp;
    end
    if (smp >= thr) begin
      r.hi = idx;
      if (!a.occ) begin
        r.lo  = idx;
        r.occ = 1'b1;
      end
    end
    return r;
  endfunction

  state_e     state_q, state_d;
  logic [7:0] bin_q, bin_d;
  logic [3:0] wdog_q, wdog_d;
  logic [8:0] thr_q, thr_d;
  logic       xcap_q, xcap_d, ycap_q, ycap_d;
  logic [8:0] xsmp_q, xsmp_d, ysmp_q, ysmp_d;
  axis_t      shx_q, shx_d, shy_q, shy_d;
  axis_t      resx_q, resx_d, resy_q, resy_d;
  logic       err_q, err_d;
  logic       load_res, timeout;

  always_comb begin
    state_d  = state_q;
    bin_d    = bin_q;
    wdog_d   = wdog_q;
    thr_d    = thr_q;
    xcap_d   = xcap_q;
    ycap_d   = ycap_q;
    xsmp_d   = xsmp_q;
    ysmp_d   = ysmp_q;
    shx_d    = shx_q;
    shy_d    = shy_q;
    resx_d   = resx_q;
    resy_d   = resy_q;
    err_d    = err_q;
    load_res = 1'b0;
    timeout  = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StReq;
          bin_d   = 8'd0;
          thr_d   = threshold;
          shx_d   = '0;
          shy_d   = '0;
          err_d   = 1'b0;
        end
      end
      StReq: begin
        xcap_d  = 1'b0;
        ycap_d  = 1'b0;
        wdog_d  = 4'd0;
        state_d = StWait;
      end
      StWait: begin
        if (xValid && !xcap_q) begin
          xcap_d = 1'b1;
          xsmp_d = xHistogramOut;
        end
        if (yValid && !ycap_q) begin
          ycap_d = 1'b1;
          ysmp_d = yHistogramOut;
        end
        if (xcap_d && ycap_d) begin
          state_d = StUpdate;
        end else if (wdog_q == 4'd15) begin
          state_d  = StDone;
          load_res = 1'b1;
          timeout  = 1'b1;
        end else begin
          wdog_d = wdog_q + 4'd1;
        end
      end
      StUpdate: begin
        shx_d = axis_step(shx_q, xsmp_q, bin_q, thr_q);
        shy_d = axis_step(shy_q, ysmp_q, bin_q, thr_q);
        if (bin_q == 8'd255) begin
          state_d  = StDone;
          load_res = 1'b1;
        end else begin
          bin_d   = bin_q + 8'd1;
          state_d = StReq;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Results become visible together with the done pulse; a timed-out scan reports zeros.
    if (load_res) begin
      resx_d = timeout ? '0 : shx_d;
      resy_d = timeout ? '0 : shy_d;
      err_d  = timeout;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      bin_q   <= 8'd0;
      wdog_q  <= 4'd0;
      thr_q   <= 9'd0;
      xcap_q  <= 1'b0;
      ycap_q  <= 1'b0;
      xsmp_q  <= 9'd0;
      ysmp_q  <= 9'd0;
      shx_q   <= '0;
      shy_q   <= '0;
      resx_q  <= '0;
      resy_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      wdog_q  <= wdog_d;
      thr_q   <= thr_d;
      xcap_q  <= xcap_d;
      ycap_q  <= ycap_d;
      xsmp_q  <= xsmp_d;
      ysmp_q  <= ysmp_d;
      shx_q   <= shx_d;
      shy_q   <= shy_d;
      resx_q  <= resx_d;
      resy_q  <= resy_d;
      err_q   <= err_d;
    end
  end

  assign readHistogram = (state_q == StReq);
  assign busy          = (state_q != StIdle);
  assign done          = (state_q == StDone);
  assign error         = err_q;
  assign xPeak         = resx_q.peak;
  assign xPeakCount    = resx_q.cnt;
  assign xMin          = resx_q.lo;
  assign xMax          = resx_q.hi;
  assign yPeak         = resy_q.peak;
  assign yPeakCount    = resy_q.cnt;
  assign yMin          = resy_q.lo;
  assign yMax          = resy_q.hi;
  assign boxValid      = resx_q.occ & resy_q.occ;

endmodule

// File: tb/tb_histogram_peak_locator.sv
// Scoreboard bench: a histogram responder model answers requests; expected results per scan
// are queued at start and compared when done pulses.
module tb_histogram_peak_locator;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [8:0] threshold;
  logic       readHistogram;
  logic [8:0] xHistogramOut, yHistogramOut;
  logic       xValid, yValid;
  logic       busy, done, error;
  logic [7:0] xPeak, yPeak, xMin, xMax, yMin, yMax;
  logic [8:0] xPeakCount, yPeakCount;
  logic       boxValid;

  histogram_peak_locator dut (
    .clk(clk), .reset(reset), .start(start), .threshold(threshold),
    .readHistogram(readHistogram), .xHistogramOut(xHistogramOut),
    .yHistogramOut(yHistogramOut), .xValid(xValid), .yValid(yValid),
    .busy(busy), .done(done), .error(error), .xPeak(xPeak), .yPeak(yPeak),
    .xPeakCount(xPeakCount), .yPeakCount(yPeakCount), .xMin(xMin), .xMax(xMax),
    .yMin(yMin), .yMax(yMax), .boxValid(boxValid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] xp, xlo, xhi, yp, ylo, yhi;
    logic [8:0] xc, yc;
    logic       box, err;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0, n_fail = 0;
  logic [8:0] xh[256], yh[256];
  int         dx = 1, dy = 1, hold_bin = -1;
  bit         extra_x = 0;
  int         req_cnt = 0, req_base = 0, cur_bin = 0, cyc = 0;
  int         x_due = -1, y_due = -1, done_cnt = 0, rd_viol = 0;
  bit         prev_rd = 0;

  // Histogram stage model: answers each request after dx/dy cycles.
  initial begin
    xValid = 0; yValid = 0; xHistogramOut = 0; yHistogramOut = 0;
    forever begin
      @(negedge clk);
      cyc++;
      xValid = 0; yValid = 0;
      if (!reset) begin
        x_due = -1; y_due = -1; prev_rd = 0;
      end else begin
        if (done) done_cnt++;
        if (readHistogram && prev_rd) rd_viol++;
        prev_rd = readHistogram;
        if (cyc == x_due) begin
          xValid = 1; xHistogramOut = xh[cur_bin];
        end else if (extra_x && x_due > 0 && cyc == x_due + 1) begin
          xValid = 1; xHistogramOut = 9'h1FF;
        end
        if (cyc == y_due && cur_bin != hold_bin) begin
          yValid = 1; yHistogramOut = yh[cur_bin];
        end
        if (readHistogram) begin
          cur_bin = (req_cnt - req_base) & 255;
          req_cnt++;
          x_due = cyc + dx; y_due = cyc + dy;
        end
      end
    end
  end

  function automatic void axis_model(input bit isy, input int thr, output logic [7:0] p,
                                     output logic [8:0] c, output logic [7:0] lo,
                                     output logic [7:0] hi, output bit occ);
    logic [8:0] v[256];
    int mv;
    mv = 0; p = 0; lo = 0; hi = 0; occ = 0;
    for (int i = 0; i < 256; i++) v[i] = isy ? yh[i] : xh[i];
    for (int i = 0; i < 256; i++) if (int'(v[i]) > mv) mv = int'(v[i]);
    c = mv[8:0];
    for (int i = 255; i >= 0; i--) if (int'(v[i]) == mv) p = i[7:0];
    for (int i = 255; i >= 0; i--) if (int'(v[i]) >= thr) begin lo = i[7:0]; occ = 1; end
    for (int i = 0; i < 256; i++) if (int'(v[i]) >= thr) hi = i[7:0];
  endfunction

  function automatic exp_t model(input int thr, input int hb);
    exp_t e;
    bit xo, yo;
    e = '0;
    if (hb >= 0) begin
      e.err = 1;
      return e;
    end
    axis_model(0, thr, e.xp, e.xc, e.xlo, e.xhi, xo);
    axis_model(1, thr, e.yp, e.yc, e.ylo, e.yhi, yo);
    e.box = xo && yo;
    return e;
  endfunction

  task automatic run_scan(input int thr, input int hb, input bit mid_start, input bit chk_lat);
    exp_t g;
    int t, d0, rq, exp_rq;
    bit seen;
    hold_bin = hb;
    sb.push_back(model(thr, hb));
    @(negedge clk);
    req_base = req_cnt; d0 = done_cnt;
    threshold = thr[8:0]; start = 1;
    @(negedge clk);
    start = 0; threshold = 9'h1AA;
    n_checks++;
    if (busy !== 1'b1 || error !== 1'b0) begin
      n_fail++; $display("FAIL start_accept busy=%b error=%b exp busy=1 error=0", busy, error);
    end
    t = 1; seen = 0;
    while (t < 4000 && !seen) begin
      start = (mid_start && (t == 10 || t == 11));
      @(negedge clk); t++;
      if (done) seen = 1;
    end
    start = (mid_start && seen);
    g = sb.pop_front();
    n_checks++;
    if (!seen) begin
      n_fail++; $display("FAIL done_timeout waited %0d cycles, exp done", t);
    end else begin
      if (xPeak !== g.xp || xPeakCount !== g.xc) begin
        n_fail++; $display("FAIL xPeak got %0d/%0d exp %0d/%0d", xPeak, xPeakCount, g.xp, g.xc);
      end
      n_checks++;
      if (yPeak !== g.yp || yPeakCount !== g.yc) begin
        n_fail++; $display("FAIL yPeak got %0d/%0d exp %0d/%0d", yPeak, yPeakCount, g.yp, g.yc);
      end
      n_checks++;
      if (xMin !== g.xlo || xMax !== g.xhi) begin
        n_fail++; $display("FAIL xMinMax got %0d..%0d exp %0d..%0d", xMin, xMax, g.xlo, g.xhi);
      end
      n_checks++;
      if (yMin !== g.ylo || yMax !== g.yhi) begin
        n_fail++; $display("FAIL yMinMax got %0d..%0d exp %0d..%0d", yMin, yMax, g.ylo, g.yhi);
      end
      n_checks++;
      if (boxValid !== g.box || error !== g.err) begin
        n_fail++;
        $display("FAIL box_err got box=%b err=%b exp box=%b err=%b", boxValid, error, g.box, g.err);
      end
      if (chk_lat) begin
        n_checks++;
        if (t < 768 || t > 770) begin
          n_fail++; $display("FAIL latency got %0d cycles exp 768..770", t);
        end
      end
      @(negedge clk);
      start = 0;
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0 || error !== g.err || xPeak !== g.xp
          || yMax !== g.yhi) begin
        n_fail++;
        $display("FAIL after_done done=%b busy=%b err=%b xPeak=%0d yMax=%0d exp 0 0 %b %0d %0d",
                 done, busy, error, xPeak, yMax, g.err, g.xp, g.yhi);
      end
    end
    start = 0;
    repeat (20) @(negedge clk);
    rq = req_cnt - req_base;
    exp_rq = (hb >= 0) ? hb + 1 : 256;
    n_checks++;
    if (rq != exp_rq || done_cnt - d0 != 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL scan_count requests=%0d dones=%0d busy=%b exp %0d 1 0",
               rq, done_cnt - d0, busy, exp_rq);
    end
  endtask

  task automatic clear_hist();
    for (int i = 0; i < 256; i++) begin xh[i] = 0; yh[i] = 0; end
  endtask

  task automatic rand_hist();
    for (int i = 0; i < 256; i++) begin
      xh[i] = 9'($urandom_range(0, 511)); yh[i] = 9'($urandom_range(0, 300));
    end
  endtask

  task automatic test_reset();
    reset = 0; start = 0; threshold = 0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, error, readHistogram, boxValid} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl got %b exp 00000", {busy, done, error, readHistogram, boxValid});
    end
    n_checks++;
    if ({xPeak, yPeak, xPeakCount, yPeakCount, xMin, xMax, yMin, yMax} !== 66'b0) begin
      n_fail++; $display("FAIL reset_results got %h exp 0",
                         {xPeak, yPeak, xPeakCount, yPeakCount, xMin, xMax, yMin, yMax});
    end
    reset = 1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_peak();
    clear_hist(); xh[40] = 50; yh[100] = 30;
    dx = 1; dy = 1; extra_x = 0;
    run_scan(10, -1, 0, 1);
  endtask

  task automatic test_tie_peak();
    for (int i = 0; i < 256; i++) begin xh[i] = 3; yh[i] = 9'(i % 7); end
    xh[5] = 77; xh[200] = 77;
    run_scan(4, -1, 0, 1);
  endtask

  task automatic test_all_zero();
    clear_hist();
    run_scan(1, -1, 0, 0);
  endtask

  task automatic test_threshold_zero();
    rand_hist();
    run_scan(0, -1, 0, 0);
  endtask

  task automatic test_skewed_strobes();
    rand_hist();
    dx = 2; dy = 2; extra_x = 0;
    run_scan(100, -1, 0, 0);
    dx = 4; dy = 1; extra_x = 1;
    run_scan(100, -1, 0, 0);
    dx = 1; dy = 4; extra_x = 1;
    run_scan(100, -1, 0, 0);
    dx = 1; dy = 1; extra_x = 0;
  endtask

  task automatic test_timeout();
    rand_hist();
    run_scan(50, 17, 1, 0);
    run_scan(50, -1, 1, 0);
  endtask

  task automatic test_reset_mid_scan();
    int w, d0;
    rand_hist();
    @(negedge clk);
    req_base = req_cnt; threshold = 9'd20; start = 1;
    @(negedge clk);
    start = 0;
    w = 0;
    while (req_cnt - req_base < 129 && w < 2000) begin
      @(negedge clk); w++;
    end
    n_checks++;
    if (w >= 2000) begin
      n_fail++; $display("FAIL mid_scan_reach got %0d requests exp 129", req_cnt - req_base);
    end
    d0 = done_cnt;
    reset = 0;
    @(negedge clk);
    n_checks++;
    if ({busy, done, readHistogram, boxValid, xPeakCount} !== 13'b0) begin
      n_fail++; $display("FAIL mid_reset_clear got %b exp 0",
                         {busy, done, readHistogram, boxValid, xPeakCount});
    end
    repeat (3) @(negedge clk);
    reset = 1;
    repeat (5) @(negedge clk);
    n_checks++;
    if (done_cnt != d0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_no_done dones=%0d busy=%b exp 0 0", done_cnt - d0, busy);
    end
    run_scan(20, -1, 0, 1);
  endtask

  initial begin
    test_reset();
    test_single_peak();
    test_tie_peak();
    test_all_zero();
    test_threshold_zero();
    test_skewed_strobes();
    test_timeout();
    test_reset_mid_scan();
    n_checks++;
    if (rd_viol != 0) begin
      n_fail++; $display("FAIL read_pulse got %0d multi-cycle requests exp 0", rd_viol);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
